alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised successor to the single-width ALU: registered arithmetic/logic unit with
//  a multi-cycle pipelined multiplier (MUL_LAT stages), OUT_VALID/BUSY handshake and
//  operand-valid checking. Sits in the datapath between operand registers and writeback.
// PARAMETERS
//  WIDTH    8  operand width; RES is 2*WIDTH
//  MUL_LAT  2  cycles from multiply issue to result (>=2)
// PORTS
//  CLK        in   1        clock, rising edge
//  RST        in   1        asynchronous, active-high reset
//  CE         in   1        issue enable; op sampled on rising CLK when CE=1
//  MODE       in   1        1=arithmetic, 0=logic
//  CMD        in   4        opcode
//  VALID      in   2        operand valid: [1]=OPB, [0]=OPA
//  OPA,OPB    in   WIDTH    operands
//  CIN        in   1        carry/borrow in
//  RES        out  2*WIDTH  result
//  OUT_VALID  out  1        1-cycle pulse: RES/flags updated this cycle
//  BUSY       out  1        multiply in flight; issues are rejected
//  ERR        out  1        illegal op / missing operand / issue while BUSY
//  OFLOW,COUT out  1        overflow, carry out
//  G,L,E      out  1        compare flags (CMP only; else 0)
// BEHAVIOUR
//  - Reset: RES=0, all flags/OUT_VALID/BUSY=0, state IDLE, mul pipe flushed (async, any time).
//  - Outputs registered; hold last value when no result is produced.
//  - Arith: 0000 ADD, 0001 SUB, 0010 ADD+CIN, 0011 SUB-CIN, 0100 INC_A, 0101 DEC_A,
//    0110 INC_B, 0111 DEC_B, 1000 CMP, 1001 MUL_INC (A+1)*(B+1), 1010 MUL_SHL (A<<1)*B,
//    1011 SADD, 1100 SSUB (signed, ALU_SIGNED_EN). Others -> ERR.
//  - Logic: 0000 AND,0001 NAND,0010 OR,0011 NOR,0100 XOR,0101 XNOR,0110 NOT_A,0111 NOT_B,
//    1000 SHR1_A,1001 SHL1_A,1010 SHR1_B,1011 SHL1_B,1100 ROL_A_B,1101 ROR_A_B (amount=
//    OPB[log2 WIDTH-1:0]; ROL/ROR with OPB upper bits nonzero -> ERR). Others -> ERR.
//  - Single-cycle ops: result + OUT_VALID=1 on the edge after issue (latency 1).
//  - Unsigned add/sub: COUT = carry/borrow (bit WIDTH), RES zero-extended. SUB/DEC: COUT=1
//    on borrow. Signed: OFLOW = two's-complement overflow, RES sign-extended to 2*WIDTH.
//  - Multiply: operands computed at WIDTH+1 bits, product truncated to 2*WIDTH;
//    OFLOW=1 if true product >= 2^(2*WIDTH). OUT_VALID MUL_LAT cycles after issue.
//  - FSM: IDLE -(CE & mul op & operands ok)-> MUL_WAIT (counter=MUL_LAT-1, BUSY=1);
//    MUL_WAIT decrements each cycle; at 0 -> IDLE, result + OUT_VALID, BUSY=0 same edge.
//  - CE=1 while BUSY: op dropped, ERR=1 & OUT_VALID=1 for one cycle, RES unchanged,
//    multiply continues unaffected. Collision on the completion edge: multiply result
//    wins, new op is rejected (ERR next cycle).
//  - Operand check: 2-operand ops need VALID=11, A-only ops VALID[0], B-only VALID[1];
//    missing -> ERR=1, OUT_VALID=1, RES=0, other flags 0, no state change.
//  - ERR cleared on next accepted result. CE=0: no issue, outputs hold, OUT_VALID=0.
//  - RST mid-multiply: pipe flushed, no later OUT_VALID from the aborted op.
// CONFIGURATION
//  ALU_SIGNED_EN defined: CMD 1011/1100 (MODE=1) perform signed add/sub with OFLOW.
//  Not defined: those opcodes decode as illegal -> ERR=1, RES=0, OFLOW=0.
// TESTING (WIDTH=8, MUL_LAT=2)
//  1 MUL_INC A=3,B=4, VALID=11 -> BUSY 1 cycle, RES=20 2 cycles later, OFLOW=0
//  2 MUL_INC A=255,B=255 -> RES=0, OFLOW=1; MUL_SHL 255,255 -> RES=16'hFC02, OFLOW=1
//  3 MUL_SHL 3,4 then ADD 5,10 next cycle -> ADD rejected (ERR=1), later RES=24, ERR=0
//  4 ADD 255,1 CIN=0 -> RES=0, COUT=1; CMP 5,10 -> L=1,G=0,E=0, latency 1
//  5 ADD with VALID=01 -> ERR=1, RES=0; NOT_A 8'h0F VALID=01 -> RES=16'h00F0
//  6 RST during MUL_WAIT -> all outputs 0 at once, no OUT_VALID afterwards;
//    SADD 127,1 -> OFLOW=1 with ALU_SIGNED_EN, ERR=1 without

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with a multi-cycle multiplier and BUSY/OUT_VALID handshake.
// Define ALU_SIGNED_EN to enable signed add/sub (MODE=1, CMD 1011/1100).
module alu_pipe #(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic               MODE,
  input  logic [3:0]         CMD,
  input  logic [1:0]         VALID,
  input  logic [WIDTH-1:0]   OPA,
  input  logic [WIDTH-1:0]   OPB,
  input  logic               CIN,
  output logic [2*WIDTH-1:0] RES,
  output logic               OUT_VALID,
  output logic               BUSY,
  output logic               ERR,
  output logic               OFLOW,
  output logic               COUT,
  output logic               G,
  output logic               L,
  output logic               E
);

  localparam int RW  = 2 * WIDTH;
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(MUL_LAT + 1);

  typedef enum logic {
    IDLE,
    MUL_WAIT
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] res_q;
  logic [RW-1:0] prod_q;
  logic          pof_q;
  logic          ov_q;
  logic          busy_q;
  logic          err_q;
  logic          ofl_q;
  logic          cout_q;
  logic          g_q;
  logic          l_q;
  logic          e_q;
  logic          rej_q;

  logic             need_a;
  logic             need_b;
  logic             legal;
  logic             is_mul;
  logic             ops_ok;
  logic             use_sum;
  logic             rot_ok;
  logic [RW-1:0]    alu_res;
  logic             alu_cout;
  logic             alu_ofl;
  logic             alu_g;
  logic             alu_l;
  logic             alu_e;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   a_x;
  logic [WIDTH:0]   b_x;
  logic [WIDTH:0]   ci_x;
  logic [WIDTH:0]   one_x;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   ma;
  logic [WIDTH:0]   mb;
  logic [RW+1:0]    prod;
  logic [RW-1:0]    rot;
  logic [SHW-1:0]   amt;
`ifdef ALU_SIGNED_EN
  logic [WIDTH-1:0] s_sum;
`endif

  assign a_x    = {1'b0, OPA};
  assign b_x    = {1'b0, OPB};
  assign ci_x   = {{WIDTH{1'b0}}, CIN};
  assign one_x  = {{WIDTH{1'b0}}, 1'b1};
  assign amt    = OPB[SHW-1:0];
  assign rot_ok = (OPB >> SHW) == '0;
  assign ops_ok = (!need_a || VALID[0]) && (!need_b || VALID[1]);

  // Product is formed at WIDTH+1 bits per operand; top two bits flag overflow.
  assign prod = {{(WIDTH+1){1'b0}}, ma} * {{(WIDTH+1){1'b0}}, mb};

  always_comb begin
    need_a   = 1'b0;
    need_b   = 1'b0;
    legal    = 1'b1;
    is_mul   = 1'b0;
    use_sum  = 1'b0;
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ofl  = 1'b0;
    alu_g    = 1'b0;
    alu_l    = 1'b0;
    alu_e    = 1'b0;
    lo       = '0;
    sum      = '0;
    ma       = '0;
    mb       = '0;
    rot      = '0;
`ifdef ALU_SIGNED_EN
    s_sum    = '0;
`endif
    if (MODE) begin
      case (CMD)
        4'b0000: begin need_a = 1'b1; need_b = 1'b1; use_sum = 1'b1; sum = a_x + b_x; end
        4'b0001: begin need_a = 1'b1; need_b = 1'b1; use_sum = 1'b1; sum = a_x - b_x; end
        4'b0010: begin need_a = 1'b1; need_b = 1'b1; use_sum = 1'b1; sum = a_x + b_x + ci_x; end
        4'b0011: begin need_a = 1'b1; need_b = 1'b1; use_sum = 1'b1; sum = a_x - b_x - ci_x; end
        4'b0100: begin need_a = 1'b1; use_sum = 1'b1; sum = a_x + one_x; end
        4'b0101: begin need_a = 1'b1; use_sum = 1'b1; sum = a_x - one_x; end
        4'b0110: begin need_b = 1'b1; use_sum = 1'b1; sum = b_x + one_x; end
        4'b0111: begin need_b = 1'b1; use_sum = 1'b1; sum = b_x - one_x; end
        4'b1000: begin
          need_a = 1'b1;
          need_b = 1'b1;
          alu_g  = OPA > OPB;
          alu_l  = OPA < OPB;
          alu_e  = OPA == OPB;
        end
        4'b1001: begin
          need_a = 1'b1; need_b = 1'b1; is_mul = 1'b1;
          ma = a_x + one_x;
          mb = b_x + one_x;
        end
        4'b1010: begin
          need_a = 1'b1; need_b = 1'b1; is_mul = 1'b1;
          ma = {OPA, 1'b0};
          mb = b_x;
        end
`ifdef ALU_SIGNED_EN
        4'b1011: begin
          need_a  = 1'b1;
          need_b  = 1'b1;
          s_sum   = OPA + OPB;
          alu_ofl = (OPA[WIDTH-1] == OPB[WIDTH-1]) &&
                    (s_sum[WIDTH-1] != OPA[WIDTH-1]);
          alu_res = {{WIDTH{s_sum[WIDTH-1]}}, s_sum};
        end
        4'b1100: begin
          need_a  = 1'b1;
          need_b  = 1'b1;
          s_sum   = OPA - OPB;
          alu_ofl = (OPA[WIDTH-1] != OPB[WIDTH-1]) &&
                    (s_sum[WIDTH-1] != OPA[WIDTH-1]);
          alu_res = {{WIDTH{s_sum[WIDTH-1]}}, s_sum};
        end
`endif
        default: legal = 1'b0;
      endcase
      if (use_sum) begin
        alu_res  = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        alu_cout = sum[WIDTH];
      end
    end else begin
      case (CMD)
        4'b0000: begin need_a = 1'b1; need_b = 1'b1; lo = OPA & OPB; end
        4'b0001: begin need_a = 1'b1; need_b = 1'b1; lo = ~(OPA & OPB); end
        4'b0010: begin need_a = 1'b1; need_b = 1'b1; lo = OPA | OPB; end
        4'b0011: begin need_a = 1'b1; need_b = 1'b1; lo = ~(OPA | OPB); end
        4'b0100: begin need_a = 1'b1; need_b = 1'b1; lo = OPA ^ OPB; end
        4'b0101: begin need_a = 1'b1; need_b = 1'b1; lo = ~(OPA ^ OPB); end
        4'b0110: begin need_a = 1'b1; lo = ~OPA; end
        4'b0111: begin need_b = 1'b1; lo = ~OPB; end
        4'b1000: begin need_a = 1'b1; lo = OPA >> 1; end
        4'b1001: begin need_a = 1'b1; lo = OPA << 1; end
        4'b1010: begin need_b = 1'b1; lo = OPB >> 1; end
        4'b1011: begin need_b = 1'b1; lo = OPB << 1; end
        4'b1100: begin
          need_a = 1'b1; need_b = 1'b1; legal = rot_ok;
          rot = {OPA, OPA} << amt;
          lo  = rot[RW-1:WIDTH];
        end
        4'b1101: begin
          need_a = 1'b1; need_b = 1'b1; legal = rot_ok;
          rot = {OPA, OPA} >> amt;
          lo  = rot[WIDTH-1:0];
        end
        default: legal = 1'b0;
      endcase
      alu_res = {{WIDTH{1'b0}}, lo};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      prod_q  <= '0;
      pof_q   <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ofl_q   <= 1'b0;
      cout_q  <= 1'b0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      ov_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rej_q) begin
            // Report the op dropped on the completion edge; a new issue now is dropped too.
            rej_q <= CE;
            err_q <= 1'b1;
            ov_q  <= 1'b1;
          end else if (CE) begin
            if (!legal || !ops_ok) begin
              res_q  <= '0;
              err_q  <= 1'b1;
              ofl_q  <= 1'b0;
              cout_q <= 1'b0;
              g_q    <= 1'b0;
              l_q    <= 1'b0;
              e_q    <= 1'b0;
              ov_q   <= 1'b1;
            end else if (is_mul) begin
              state_q <= MUL_WAIT;
              cnt_q   <= CW'(MUL_LAT - 1);
              prod_q  <= prod[RW-1:0];
              pof_q   <= |prod[RW+1:RW];
              busy_q  <= 1'b1;
            end else begin
              res_q  <= alu_res;
              err_q  <= 1'b0;
              ofl_q  <= alu_ofl;
              cout_q <= alu_cout;
              g_q    <= alu_g;
              l_q    <= alu_l;
              e_q    <= alu_e;
              ov_q   <= 1'b1;
            end
          end
        end
        MUL_WAIT: begin
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= prod_q;
            ofl_q   <= pof_q;
            err_q   <= 1'b0;
            cout_q  <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            ov_q    <= 1'b1;
            busy_q  <= 1'b0;
            rej_q   <= CE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (CE) begin
              err_q <= 1'b1;
              ov_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign RES       = res_q;
  assign OUT_VALID = ov_q;
  assign BUSY      = busy_q;
  assign ERR       = err_q;
  assign OFLOW     = ofl_q;
  assign COUT      = cout_q;
  assign G         = g_q;
  assign L         = l_q;
  assign E         = e_q;

endmodule
